// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// Holds the FSM encoding, counter widths and default configuration.
package reg_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int unsigned WR_COUNT_W         = 16;
  localparam int unsigned CLR_CNT_W          = 4;
  localparam int unsigned DEFAULT_N_REQ      = 4;
  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam int unsigned DEFAULT_CLR_CYCLES = 2;

  // Index width for a requester count; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr_i + 1,
// wrapping modulo N_REQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEFAULT_N_REQ,
  parameter int unsigned IDX_W = idx_width(DEFAULT_N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    pick_o   = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // The current holder is visited last, so it is re-granted only when alone.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(ptr_i) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        pick_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter and clear sequencer for an enable-gated flop bank.
// Define REG_ARB_CLEAR_EN to build the CLEAR state and ff_reset_n sequencing.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = DEFAULT_N_REQ,
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned CLR_CYCLES = DEFAULT_CLR_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   a_reset_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] wdata_i,
  input  logic                   clr_req_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [WIDTH-1:0]       ff_d_o,
  output logic                   ff_enable_n_o,
  output logic                   ff_reset_n_o,
  output logic                   busy_o,
  output logic [WR_COUNT_W-1:0]  wr_count_o
);

  localparam int unsigned IDX_W = idx_width(N_REQ);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [WIDTH-1:0]        ff_d_q, ff_d_d;
  logic                    en_n_q, en_n_d;
  logic [WR_COUNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]        pick_oh;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic [WIDTH-1:0]        pick_data;

`ifdef REG_ARB_CLEAR_EN
  logic [CLR_CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic                    rst_n_q, rst_n_d;
  logic                    busy_q, busy_d;
`else
  logic                    unused_cfg;
  assign unused_cfg = ^{clr_req_i, CLR_CNT_W'(CLR_CYCLES)};
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .pick_o  (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // One-hot data mux keeps slice indices constant.
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_data = pick_data | wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    ff_d_d    = ff_d_q;
    en_n_d    = 1'b1;
    cnt_d     = cnt_q;
`ifdef REG_ARB_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
    rst_n_d   = 1'b1;
    busy_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef REG_ARB_CLEAR_EN
        // Clear wins over any request sampled on the same edge.
        if (clr_req_i) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = CLR_CNT_W'(CLR_CYCLES - 1);
          rst_n_d   = 1'b0;
          busy_d    = 1'b1;
        end else
`endif
        if (pick_valid) begin
          gnt_d  = pick_oh;
          ff_d_d = pick_data;
          en_n_d = 1'b0;
          ptr_d  = pick_idx;
          cnt_d  = cnt_q + 1'b1;
        end
      end
`ifdef REG_ARB_CLEAR_EN
      ST_CLEAR: begin
        if (clr_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
          rst_n_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge a_reset_i) begin
    if (a_reset_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(N_REQ - 1);
      gnt_q     <= '0;
      ff_d_q    <= '0;
      en_n_q    <= 1'b1;
      cnt_q     <= '0;
`ifdef REG_ARB_CLEAR_EN
      clr_cnt_q <= '0;
      rst_n_q   <= 1'b1;
      busy_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      ff_d_q    <= ff_d_d;
      en_n_q    <= en_n_d;
      cnt_q     <= cnt_d;
`ifdef REG_ARB_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= busy_d;
`endif
    end
  end

  assign gnt_o         = gnt_q;
  assign ff_d_o        = ff_d_q;
  assign ff_enable_n_o = en_n_q;
  assign wr_count_o    = cnt_q;
`ifdef REG_ARB_CLEAR_EN
  assign ff_reset_n_o  = rst_n_q;
  assign busy_o        = busy_q;
`else
  assign ff_reset_n_o  = 1'b1;
  assign busy_o        = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a driver pushes model predictions, a
// negedge monitor pops and compares against the registered outputs.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned C = 2;
`ifdef REG_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic           clk;
  logic           a_reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           clr_req;
  logic [N-1:0]   gnt;
  logic [W-1:0]   ff_d;
  logic           ff_enable_n;
  logic           ff_reset_n;
  logic           busy;
  logic [15:0]    wr_count;

  reg_write_arbiter #(
    .N_REQ      (N),
    .WIDTH      (W),
    .CLR_CYCLES (C)
  ) dut (
    .clk_i         (clk),
    .a_reset_i     (a_reset),
    .req_i         (req),
    .wdata_i       (wdata),
    .clr_req_i     (clr_req),
    .gnt_o         (gnt),
    .ff_d_o        (ff_d),
    .ff_enable_n_o (ff_enable_n),
    .ff_reset_n_o  (ff_reset_n),
    .busy_o        (busy),
    .wr_count_o    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] ffd;
    logic         en_n;
    logic         rst_n;
    logic         busy;
    logic [15:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [W-1:0] wd [N];

  // Reference state: last granted index, edges of clear still to run, writes done.
  int          m_ptr;
  int          m_clr_after;
  int unsigned m_cnt;
  logic [W-1:0] m_ffd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr       = N - 1;
    m_clr_after = 0;
    m_cnt       = 0;
    m_ffd       = '0;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic c);
    exp_t e;
    req     = r;
    clr_req = c;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = wd[i];
    e.gnt   = '0;
    e.en_n  = 1'b1;
    e.rst_n = 1'b1;
    e.busy  = 1'b0;
    if (m_clr_after > 0) begin
      m_clr_after--;
      if (m_clr_after > 0) begin
        e.rst_n = 1'b0;
        e.busy  = 1'b1;
      end
    end else if (CLEAR_EN && c) begin
      m_clr_after = C;
      e.rst_n     = 1'b0;
      e.busy      = 1'b1;
    end else begin
      for (int j = 1; j <= N; j++) begin
        int cand;
        cand = (m_ptr + j) % N;
        if (r[cand]) begin
          e.gnt[cand] = 1'b1;
          m_ffd       = wd[cand];
          e.en_n      = 1'b0;
          m_ptr       = cand;
          m_cnt       = (m_cnt + 1) % 65536;
          break;
        end
      end
    end
    e.ffd = m_ffd;
    e.cnt = 16'(m_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Reset lands between edges and is checked before the next clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    a_reset = 1'b1;
    sb_q.delete();
    model_reset();
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ff_d", 32'(ff_d), 32'h0);
    chk("rst_enable_n", 32'(ff_enable_n), 32'h1);
    chk("rst_reset_n", 32'(ff_reset_n), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    @(negedge clk);
    #1;
    a_reset = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("ff_d", 32'(ff_d), 32'(e.ffd));
      chk("ff_enable_n", 32'(ff_enable_n), 32'(e.en_n));
      chk("ff_reset_n", 32'(ff_reset_n), 32'(e.rst_n));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("wr_count", 32'(wr_count), 32'(e.cnt));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1;
    req     = '0;
    clr_req = 1'b0;
    wdata   = '0;
    for (int i = 0; i < N; i++) wd[i] = '0;
    model_reset();
    do_reset();

    repeat (5) step(4'b0000, 1'b0);

    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    repeat (8) step(4'b1111, 1'b0);
    repeat (3) step(4'b0100, 1'b0);

    // Clear and requests together, then requests continue through the clear.
    step(4'b0011, 1'b1);
    repeat (4) step(4'b0011, 1'b0);

    // Reset in the middle of a clear.
    step(4'b0011, 1'b1);
    step(4'b0000, 1'b0);
    do_reset();
    repeat (2) step(4'b1000, 1'b0);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) wd[i] = W'($urandom);
      step(N'($urandom), ($urandom_range(0, 19) == 0));
    end

    // Counter wrap after 65537 writes, with a clear pulse at the end.
    do_reset();
    wd[0] = 8'h5a;
    repeat (65537) step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    chk("wrap_wr_count", 32'(wr_count), 32'h1);
    step(4'b0011, 1'b1);
    repeat (4) step(4'b0011, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter and sequencer for a shared bank of enable-gated D flip-flops. Multiple requesters compete for write access; the block selects one per cycle and drives the bank's data bus and active-low enable. It also sequences multi-cycle clear operations through the bank's active-low synchronous reset. It sits between the requesting agents and the flop bank, and is the only driver of the bank's control inputs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of the flop bank
- CLR_CYCLES, 2, cycles the bank's sync reset is held low per clear (1..15)

- clk  in  1  rising-edge clock
- a_reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester write request, level
- wdata  in  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- clr_req  in  1  request a bank clear, level
- gnt  out  N_REQ  one-hot grant, registered
- ff_d  out  WIDTH  data to bank, registered
- ff_enable_n  out  1  bank write enable, active low, registered
- ff_reset_n  out  1  bank synchronous reset, active low, registered
- busy  out  1  high while in CLEAR
- wr_count  out  16  completed-write counter

## Operation
- States: IDLE, CLEAR (CLEAR exists only with the macro; see Configuration).
- Reset values: gnt=0, ff_d=0, ff_enable_n=1, ff_reset_n=1, busy=0, wr_count=0, rr pointer=N_REQ-1 (requester 0 has first priority), state=IDLE, clear counter=0.
- IDLE, each edge:
  - No req bit set → gnt=0, ff_enable_n=1, ff_d holds.
  - Otherwise pick the first set req searching from pointer+1 modulo N_REQ.
  - Register gnt=one-hot(pick), ff_d=wdata slice of pick, ff_enable_n=0.
  - Set pointer=pick; wr_count+=1 (wraps 0xFFFF→0).
- One write per cycle; back-to-back grants to different requesters are allowed.
- The same requester is re-granted consecutively only if no other req is set.
- A requester that keeps req high after its grant is served again in round-robin order.
- Grant is based on req sampled at the edge. A req dropped after the sampling edge does not cancel the issued write.
- clr_req sampled high in IDLE → CLEAR. Clear has priority over every req in the same cycle; no gnt is issued on that edge.
- CLEAR:
  - ff_reset_n=0, ff_enable_n=1, gnt=0, busy=1 for exactly CLR_CYCLES cycles.
  - Then return to IDLE, restoring ff_reset_n=1 and busy=0.
  - req and clr_req are ignored while in CLEAR.
  - The pointer is unchanged; wr_count is not incremented.
- Asserting a_reset in any state forces all reset values immediately, without waiting for a clock edge.

## Timing
- Request sampled at edge k → gnt, ff_d, ff_enable_n valid after edge k → bank captures at edge k+1. Request-to-capture latency: 2 edges.
- clr_req sampled at edge k → ff_reset_n low after edge k through edge k+CLR_CYCLES. First new grant is possible on edge k+CLR_CYCLES+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- REG_ARB_CLEAR_EN defined: CLEAR state, clear counter, busy and ff_reset_n sequencing as described above.
- REG_ARB_CLEAR_EN undefined:
  - clr_req is ignored, ff_reset_n is constant 1, busy is constant 0.
  - The FSM reduces to IDLE only; port list is unchanged.

## Structure
- Shared package reg_arb_pkg:
  - state encodings ST_IDLE=1'b0, ST_CLEAR=1'b1
  - WR_COUNT_W=16
  - default widths
- Sub-module rr_pick:
  - combinational round-robin picker
  - inputs: req vector, pointer; outputs: one-hot pick, index, any-valid
  - instantiated once

## Test plan
- Reset, then req=4'b0000 for 5 cycles → gnt=0, ff_enable_n=1, ff_reset_n=1, wr_count=0.
- req=4'b1111 held 8 cycles, wdata slices 0x11,0x22,0x33,0x44 → gnt sequence 0001,0010,0100,1000,0001…; ff_d 0x11,0x22,0x33,0x44,…; wr_count=8.
- req=4'b0100 only, held 3 cycles → gnt=0100 three consecutive cycles, ff_enable_n low throughout, ff_d=wdata[2].
- clr_req and req=4'b0011 rise on the same edge, CLR_CYCLES=2 → ff_reset_n low exactly 2 cycles, busy high, gnt=0; next cycle gnt=0001.
- a_reset asserted mid-CLEAR (between edges) → ff_reset_n=1, busy=0, gnt=0 immediately; after release with req=4'b1000, first gnt=1000.
- 65 537 single writes → wr_count wraps and reads 1; without REG_ARB_CLEAR_EN, a clr_req pulse leaves ff_reset_n=1 and grants uninterrupted.
